// File: rtl/vga_timing_bar.sv
// ---------------------------------------------------------------------------
// vga_timing_bar
//
// Single-clock VGA timing generator with a song-progress bar overlay.
// A clock-enable divider (CLK_DIV clk cycles per pixel) stands in for a
// separate pixel clock. Each pixel period the output registers take
// sync, data-enable, coordinates and colour computed from the current
// (h, v) counter position. All outputs are therefore aligned with each
// other and change one clk after the counter state they describe.
//
// The progress value and pause flag are sampled once per frame at the
// start of vertical blanking (h == 0, v == V_ACTIVE), so a frame is never
// drawn with a mix of old and new inputs. While paused, the filled part
// of the bar alternates green / yellow every BLINK_FRAMES frames.
//
// Optional feature (compile-time macro):
//   VGA_BORDER_EN  - when defined, the outermost ring of active pixels is
//                    drawn white, overriding the bar and the background.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   progress     in   [7:0] song progress 0..255
//   song_pause   in   1 = playback paused
//   pix_en       out  one-clk pulse per pixel period (new pixel on outputs)
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   de           out  active-video flag
//   xpos, ypos   out  [9:0] coordinate of the displayed pixel (0 when de=0)
//   frame_start  out  one-clk pulse when pixel (0,0) is output
//   R, G, B      out  [COLOR_W-1:0] colour channels
//
// Counters and coordinates are 10 bits wide, so H_TOTAL and V_TOTAL must
// not exceed 1024.
// ---------------------------------------------------------------------------
module vga_timing_bar #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CLK_DIV      = 4,
   parameter int HS_POL       = 0,
   parameter int VS_POL       = 0,
   parameter int COLOR_W      = 4,
   parameter int BAR_Y0       = 400,
   parameter int BAR_H        = 16,
   parameter int BLINK_FRAMES = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         progress,
   input  logic               song_pause,
   output logic               pix_en,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [9:0]         xpos,
   output logic [9:0]         ypos,
   output logic               frame_start,
   output logic [COLOR_W-1:0] R,
   output logic [COLOR_W-1:0] G,
   output logic [COLOR_W-1:0] B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST_C   = DIV_W'(CLK_DIV - 1);
   localparam logic [BLK_W-1:0] BLINK_LAST_C = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [9:0]       H_LAST_C     = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST_C     = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_ACT_C      = 10'(H_ACTIVE);
   localparam logic [9:0]       V_ACT_C      = 10'(V_ACTIVE);
   localparam logic [9:0]       H_MAX_C      = 10'(H_ACTIVE - 1);
   localparam logic [9:0]       V_MAX_C      = 10'(V_ACTIVE - 1);
   localparam logic [9:0]       HS_START_C   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_STOP_C    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]       VS_START_C   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_STOP_C    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]       BAR_TOP_C    = 10'(BAR_Y0);
   localparam logic [9:0]       BAR_END_C    = 10'(BAR_Y0 + BAR_H);
   localparam logic [17:0]      H_ACT_W_C    = 18'(H_ACTIVE);
   localparam logic             HS_ACT_C     = (HS_POL != 0);
   localparam logic             VS_ACT_C     = (VS_POL != 0);

   localparam logic [COLOR_W-1:0] ONES_C = '1;
   // Only the channel MSB set: mid grey.
   localparam logic [COLOR_W-1:0] GREY_C = ONES_C ^ (ONES_C >> 1);

   // Sync level for a counter position relative to its pulse window.
   function automatic logic sync_level(input logic [9:0] pos,
                                       input logic [9:0] start,
                                       input logic [9:0] stop,
                                       input logic       act);
      if ((pos >= start) && (pos < stop)) begin
         sync_level = act;
      end else begin
         sync_level = ~act;
      end
   endfunction

   // Counter / latch state
   logic [DIV_W-1:0]   div_cnt_r;
   logic [9:0]         h_cnt_r;
   logic [9:0]         v_cnt_r;
   logic [7:0]         prog_q_r;
   logic               pause_q_r;
   logic               phase_r;
   logic [BLK_W-1:0]   blink_cnt_r;

   // Registered outputs
   logic               pix_en_r;
   logic               hsync_r;
   logic               vsync_r;
   logic               de_r;
   logic [9:0]         xpos_r;
   logic [9:0]         ypos_r;
   logic               frame_start_r;
   logic [COLOR_W-1:0] r_r;
   logic [COLOR_W-1:0] g_r;
   logic [COLOR_W-1:0] b_r;

   // Combinational next values
   logic               tick_s;
   logic               h_last_s;
   logic               v_last_s;
   logic [9:0]         h_nxt_s;
   logic [9:0]         v_nxt_s;
   logic               latch_s;
   logic [BLK_W-1:0]   blink_nxt_s;
   logic               phase_nxt_s;
   logic               de_s;
   logic               hsync_s;
   logic               vsync_s;
   logic               in_bar_s;
   logic               border_s;
   logic [17:0]        product_s;
   logic [9:0]         fill_w_s;
   logic [COLOR_W-1:0] r_s;
   logic [COLOR_W-1:0] g_s;
   logic [COLOR_W-1:0] b_s;

   assign tick_s = (div_cnt_r == DIV_LAST_C);

   // Next counter positions and the once-per-frame latch strobe.
   always_comb begin
      h_last_s = (h_cnt_r == H_LAST_C);
      v_last_s = (v_cnt_r == V_LAST_C);
      h_nxt_s  = h_cnt_r;
      v_nxt_s  = v_cnt_r;
      if (tick_s) begin
         if (h_last_s) begin
            h_nxt_s = 10'd0;
            if (v_last_s) begin
               v_nxt_s = 10'd0;
            end else begin
               v_nxt_s = v_cnt_r + 10'd1;
            end
         end else begin
            h_nxt_s = h_cnt_r + 10'd1;
         end
      end else begin
         h_nxt_s = h_cnt_r;
         v_nxt_s = v_cnt_r;
      end
      // Start of vertical blanking: nothing visible is being drawn.
      latch_s = tick_s && (h_cnt_r == 10'd0) && (v_cnt_r == V_ACT_C);
   end

   // Blink counter and phase update, evaluated against the new pause value.
   always_comb begin
      blink_nxt_s = blink_cnt_r;
      phase_nxt_s = phase_r;
      if (latch_s) begin
         if (song_pause) begin
            if (blink_cnt_r == BLINK_LAST_C) begin
               blink_nxt_s = '0;
               phase_nxt_s = ~phase_r;
            end else begin
               blink_nxt_s = blink_cnt_r + BLK_W'(1);
               phase_nxt_s = phase_r;
            end
         end else begin
            blink_nxt_s = '0;
            phase_nxt_s = 1'b0;
         end
      end else begin
         blink_nxt_s = blink_cnt_r;
         phase_nxt_s = phase_r;
      end
   end

   // Pixel value for the current counter position.
   always_comb begin
      de_s      = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
      hsync_s   = sync_level(h_cnt_r, HS_START_C, HS_STOP_C, HS_ACT_C);
      vsync_s   = sync_level(v_cnt_r, VS_START_C, VS_STOP_C, VS_ACT_C);
      in_bar_s  = (v_cnt_r >= BAR_TOP_C) && (v_cnt_r < BAR_END_C);
      product_s = 18'(prog_q_r) * H_ACT_W_C;
      // Full scale maps to the whole line so a finished song has no gap.
      if (prog_q_r == 8'd255) begin
         fill_w_s = H_ACT_C;
      end else begin
         fill_w_s = 10'(product_s >> 8);
      end
`ifdef VGA_BORDER_EN
      border_s = de_s && ((h_cnt_r == 10'd0) || (h_cnt_r == H_MAX_C) ||
                          (v_cnt_r == 10'd0) || (v_cnt_r == V_MAX_C));
`else
      border_s = 1'b0;
`endif
      r_s = '0;
      g_s = '0;
      b_s = '0;
      if (border_s) begin
         r_s = ONES_C;
         g_s = ONES_C;
         b_s = ONES_C;
      end else if (de_s && in_bar_s) begin
         if (h_cnt_r < fill_w_s) begin
            g_s = ONES_C;
            b_s = '0;
            if (pause_q_r && phase_r) begin
               r_s = ONES_C;
            end else begin
               r_s = '0;
            end
         end else begin
            r_s = GREY_C;
            g_s = GREY_C;
            b_s = GREY_C;
         end
      end else begin
         r_s = '0;
         g_s = '0;
         b_s = '0;
      end
   end

   // Clock-enable divider and raster counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= '0;
         h_cnt_r   <= 10'd0;
         v_cnt_r   <= 10'd0;
      end else begin
         if (tick_s) begin
            div_cnt_r <= '0;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end
         h_cnt_r <= h_nxt_s;
         v_cnt_r <= v_nxt_s;
      end
   end

   // Per-frame input latch and blink state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_q_r    <= 8'd0;
         pause_q_r   <= 1'b0;
         blink_cnt_r <= '0;
         phase_r     <= 1'b0;
      end else begin
         if (latch_s) begin
            prog_q_r  <= progress;
            pause_q_r <= song_pause;
         end
         blink_cnt_r <= blink_nxt_s;
         phase_r     <= phase_nxt_s;
      end
   end

   // Output registers, loaded once per pixel period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_en_r      <= 1'b0;
         frame_start_r <= 1'b0;
         hsync_r       <= ~HS_ACT_C;
         vsync_r       <= ~VS_ACT_C;
         de_r          <= 1'b0;
         xpos_r        <= 10'd0;
         ypos_r        <= 10'd0;
         r_r           <= '0;
         g_r           <= '0;
         b_r           <= '0;
      end else begin
         pix_en_r      <= tick_s;
         frame_start_r <= tick_s && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
         if (tick_s) begin
            hsync_r <= hsync_s;
            vsync_r <= vsync_s;
            de_r    <= de_s;
            xpos_r  <= de_s ? h_cnt_r : 10'd0;
            ypos_r  <= de_s ? v_cnt_r : 10'd0;
            r_r     <= r_s;
            g_r     <= g_s;
            b_r     <= b_s;
         end
      end
   end

   assign pix_en      = pix_en_r;
   assign frame_start = frame_start_r;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign de          = de_r;
   assign xpos        = xpos_r;
   assign ypos        = ypos_r;
   assign R           = r_r;
   assign G           = g_r;
   assign B           = b_r;

endmodule

// File: tb/tb_vga_timing_bar.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_bar
//
// Small raster (8/2/2/2 x 6/1/1/1, CLK_DIV=2, 4-bit colour, bar on lines
// 2..3, BLINK_FRAMES=2). The reference model derives the displayed pixel
// directly from the number of clk edges since reset release
// (pixel index = edges / CLK_DIV - 1) and keeps per-frame latched inputs;
// the blink phase follows from the length of the current run of paused
// frames. Inputs follow a script (steady 128, 255, a 64->192 change in the
// middle of a frame, a paused stretch) then turn random. One mid-frame
// reset is applied at pixel (5,3).
// ---------------------------------------------------------------------------
module tb_vga_timing_bar;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 6, VF = 1, VS = 1, VB = 1;
   localparam int CD = 2, CW = 4, BY = 2, BH = 2, BF = 2;
   localparam int HT = HA + HF + HS + HB;   // 14
   localparam int VT = VA + VF + VS + VB;   // 9
   localparam int FT = HT * VT;             // 126
   localparam int FCLK = FT * CD;           // 252 clk per frame
   localparam logic [36:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 12'd0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    progress = 8'd0;
   logic          song_pause = 1'b0;
   logic          pix_en, hsync, vsync, de, frame_start;
   logic [9:0]    xpos, ypos;
   logic [CW-1:0] R, G, B;
   logic [36:0]   act_s;

   int checks = 0;
   int errors = 0;

   vga_timing_bar #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(CD), .HS_POL(0), .VS_POL(0), .COLOR_W(CW),
      .BAR_Y0(BY), .BAR_H(BH), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .progress(progress), .song_pause(song_pause),
      .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .de(de),
      .xpos(xpos), .ypos(ypos), .frame_start(frame_start),
      .R(R), .G(G), .B(B)
   );

   always #5 clk = ~clk;

   assign act_s = {pix_en, hsync, vsync, de, xpos, ypos, frame_start, R, G, B};

   task automatic chk(input string name, input int cyc, input logic [36:0] act,
                      input logic [36:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int cyc, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Expected colour of pixel (h,v) for a frame drawn with the given latched state.
   function automatic logic [11:0] exp_rgb(input int h, input int v, input int prog,
                                           input int pause, input int phase);
      int fill;
      logic [3:0] r, g, b;
      r = 4'h0; g = 4'h0; b = 4'h0;
      if (h < HA && v < VA) begin
         fill = (prog == 255) ? HA : (prog * HA) / 256;
         if (v >= BY && v < BY + BH) begin
            if (h < fill) begin
               g = 4'hF;
               if (pause != 0 && phase != 0) r = 4'hF;
            end else begin
               r = 4'h8; g = 4'h8; b = 4'h8;
            end
         end
`ifdef VGA_BORDER_EN
         if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
            r = 4'hF; g = 4'hF; b = 4'hF;
         end
`endif
      end
      return {r, g, b};
   endfunction

   initial begin
      int cyc, n, p, idx, h, v, pe_cnt;
      int m_prog, m_pause, m_run, m_phase;
      bit pe, dd, fs, hs_e, vs_e, seen_fs, did_rst;
      logic [36:0] e;

      cyc = 0; n = 0; pe_cnt = 0; seen_fs = 1'b0; did_rst = 1'b0;
      m_prog = 0; m_pause = 0; m_run = 0; m_phase = 0;
      h = -1; v = -1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", cyc, act_s, RST_VEC);
      progress = 8'd128;
      rst_n = 1'b1;

      while (cyc < 36 * FCLK) begin
         @(posedge clk);
         #1;
         cyc++;
         n++;
         p  = n / CD;
         pe = (n % CD) == 0;
         if (p == 0) begin
            e = RST_VEC;
            h = -1; v = -1;
         end else begin
            idx  = p - 1;
            h    = idx % HT;
            v    = (idx / HT) % VT;
            dd   = (h < HA) && (v < VA);
            hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
            vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
            fs   = pe && (h == 0) && (v == 0);
            e = {pe, hs_e, vs_e, dd, dd ? 10'(h) : 10'd0, dd ? 10'(v) : 10'd0, fs,
                 exp_rgb(h, v, m_prog, m_pause, m_phase)};
         end
         chk("pixel", cyc, act_s, e);

         // Hand-computed pins for the model itself.
         if (n == 1) chk_int("first_clk_pix_en", cyc, int'(pix_en), 0);
         if (n == CD) begin
            chk_int("first_pix_frame_start", cyc, int'(frame_start), 1);
            chk_int("first_pix_de", cyc, int'(de), 1);
         end
         if (pe && h == 10) chk_int("hsync_low_h10", cyc, int'(hsync), 0);
         if (pe && h == 9)  chk_int("hsync_high_h9", cyc, int'(hsync), 1);
         if (pe && h == 0 && v == 7) chk_int("vsync_low_v7", cyc, int'(vsync), 0);
         if (pe && v == BY && m_prog == 128 && m_pause == 0) begin
            if (h == 3) chk_int("p128_x3_green", cyc, int'({R, G, B}), 12'h0F0);
            if (h == 4) chk_int("p128_x4_grey", cyc, int'({R, G, B}), 12'h888);
         end
         if (pe && v == BY && h == 7 && m_prog == 255 && m_pause == 0)
            chk_int("p255_x7_green", cyc, int'({R, G, B}), 12'h0F0);
         if (pe && v == BY && m_prog == 64) begin
            if (h == 1) chk_int("p64_x1_green", cyc, int'(G), 15);
            if (h == 2) chk_int("p64_x2_grey", cyc, int'(G), 8);
         end
         if (pe && v == BY && h == 0 && m_prog == 128 && m_pause != 0 && m_phase != 0)
            chk_int("blink_yellow", cyc, int'({R, G, B}), 12'hFF0);

         if (pix_en) pe_cnt++;
         if (frame_start) begin
            if (seen_fs) chk_int("frame_len", cyc, pe_cnt, FT);
            seen_fs = 1'b1;
            pe_cnt = 0;
         end

         // Per-frame latch at the start of vertical blanking.
         if (pe && p > 0 && h == 0 && v == VA) begin
            m_prog  = progress;
            m_pause = song_pause;
            m_run   = song_pause ? m_run + 1 : 0;
            m_phase = (m_run / BF) % 2;
         end

         // Stimulus for the next cycles.
         if (cyc < 3 * FCLK) begin
            progress = 8'd128;
         end else if (cyc < 6 * FCLK) begin
            progress = 8'd255;
         end else if (cyc < 7 * FCLK + 84) begin
            progress = 8'd64;
         end else if (cyc < 9 * FCLK) begin
            progress = 8'd192;
         end else if (cyc < 20 * FCLK) begin
            progress = 8'd128;
            song_pause = (cyc < 19 * FCLK);
         end else begin
            if ($urandom_range(0, 19) == 0) progress = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 399) == 0) song_pause = ~song_pause;
         end

         // One mid-frame reset at pixel (5,3).
         if (!did_rst && cyc > 26 * FCLK && pe && h == 5 && v == 3) begin
            did_rst = 1'b1;
            rst_n = 1'b0;
            #1;
            chk("midframe_reset", cyc, act_s, RST_VEC);
            @(posedge clk);
            #1;
            cyc++;
            chk("reset_held", cyc, act_s, RST_VEC);
            rst_n = 1'b1;
            n = 0; pe_cnt = 0; seen_fs = 1'b0;
            m_prog = 0; m_pause = 0; m_run = 0; m_phase = 0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
